// File: rtl/pipeline_pkg.sv
// Constants shared by the front-end pipeline: default datapath width, fetch
// stride and the mask that forces a PC onto a word boundary.
package pipeline_pkg;
   localparam int XLEN_DEF   = 32;
   localparam int WORD_BYTES = 4;
   // Sized wide enough for any XLEN up to 64; users slice to their width.
   localparam logic [63:0] PC_ALIGN_MASK = ~64'(WORD_BYTES - 1);
endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with a synchronous flush that overrides push and pop.
// Head data is presented combinationally.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic [PW:0]      count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             full, do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full    = (cnt_q == (PW+1)'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rptr_q];
   assign do_pop  = pop_i && !empty_o;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_push = push_i && (!full || do_pop);

   always_comb begin
      wptr_d = do_push ? wptr_q + PW'(1) : wptr_q;
      rptr_d = do_pop  ? rptr_q + PW'(1) : rptr_q;
      cnt_d  = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
      end
   end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into a queue, and redirect handling that drops stale responses.
module fetch_queue
   import pipeline_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc_plus4,
   input  logic            id_ready
);
   localparam int              CW    = $clog2(DEPTH) + 1;
   localparam logic [XLEN-1:0] ALIGN = PC_ALIGN_MASK[XLEN-1:0];
   localparam logic [XLEN-1:0] INC   = XLEN'(WORD_BYTES);

   logic [XLEN-1:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
   logic [CW-1:0]     infl_q, infl_d, disc_q, disc_d, fifo_cnt;
   logic [CW:0]       credits_used;
   logic              run_q, grant, accept, push, pop, fifo_empty;
   logic [2*XLEN-1:0] fifo_rdata;

   assign redir_pc     = redirect_pc & ALIGN;
   // Outstanding requests reserve a slot, so a returning response always fits.
   assign credits_used = {1'b0, fifo_cnt} + {1'b0, infl_q};
   assign imem_req     = run_q && (credits_used < (CW+1)'(DEPTH));
   assign imem_addr    = pc_q;
   assign grant        = imem_req && imem_gnt;
   assign accept       = imem_rvalid && (disc_q == '0);
   assign push         = accept && !redirect_valid;
   assign pop          = id_valid && id_ready && !redirect_valid;
   assign id_valid     = !fifo_empty;
   assign id_instr     = fifo_rdata[2*XLEN-1:XLEN];
   assign id_pc_plus4  = fifo_rdata[XLEN-1:0];

   always_comb begin
      infl_d   = infl_q + CW'(grant) - CW'(imem_rvalid);
      pc_d     = grant  ? pc_q + INC     : pc_q;
      rsp_pc_d = accept ? rsp_pc_q + INC : rsp_pc_q;
      disc_d   = (imem_rvalid && disc_q != '0) ? disc_q - CW'(1) : disc_q;
      // Everything still outstanding after this cycle belongs to the old path.
      if (redirect_valid) begin
         pc_d     = redir_pc;
         rsp_pc_d = redir_pc;
         disc_d   = infl_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         infl_q   <= '0;
         disc_q   <= '0;
      end else begin
         run_q    <= 1'b1;
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         infl_q   <= infl_d;
         disc_q   <= disc_d;
      end
   end

   sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect_valid),
      .push_i  (push),
      .wdata_i ({imem_rdata, rsp_pc_q + INC}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory model returns ~addr after a set latency.
module tb_fetch_queue;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid, id_ready = 1'b0;
   logic [31:0] id_instr, id_pc_plus4;
   int          checks = 0, failures = 0;
   int          lat = 1, cyc = 0;

   typedef struct {logic [31:0] addr; int due;} pend_t;
   pend_t pq[$];

   typedef struct {
      logic ready; logic gnt;
      logic exp_req; logic [31:0] exp_addr;
      logic exp_valid; logic [31:0] exp_instr; logic [31:0] exp_pc4;
   } vec_t;
   vec_t tbl[11];
   logic [31:0] heads[5], pc4s[5];

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
      .id_ready(id_ready)
   );

   // In-order memory: a grant in cycle c returns ~addr in cycle c+lat.
   always @(negedge clk) begin
      #2;
      cyc++;
      if (!rst_n) begin
         pq.delete();
         imem_rvalid = 1'b0;
      end else begin
         if (pq.size() > 0 && pq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~pq[0].addr;
            void'(pq.pop_front());
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
         end
         if (imem_req && imem_gnt) pq.push_back('{imem_addr, cyc + lat});
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input int l, input logic g, input logic r);
      @(negedge clk);
      rst_n = 1'b0; lat = l; imem_gnt = g; id_ready = r;
      redirect_valid = 1'b0; redirect_pc = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_valid", {31'b0, id_valid}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'hFFFF_FFFF, 32'h04};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'hFFFF_FFFB, 32'h08};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hFFFF_FFF7, 32'h0C};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hFFFF_FFF3, 32'h10};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'hFFFF_FFEF, 32'h14};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'hFFFF_FFEB, 32'h18};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b0, 32'h0, 32'h0};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h0, 32'h0};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'hFFFF_FFE7, 32'h1C};
      heads = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFF7, 32'hFFFF_FFF3, 32'hFFFF_FFEF};
      pc4s  = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};

      // Streaming with one-cycle latency, including grant stalls.
      do_reset(1, 1'b1, 1'b1);
      foreach (tbl[i]) begin
         nxt();
         id_ready = tbl[i].ready; imem_gnt = tbl[i].gnt;
         chk($sformatf("stream%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].exp_req});
         chk($sformatf("stream%0d_addr", i), imem_addr, tbl[i].exp_addr);
         chk($sformatf("stream%0d_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].exp_valid});
         if (tbl[i].exp_valid) begin
            chk($sformatf("stream%0d_instr", i), id_instr, tbl[i].exp_instr);
            chk($sformatf("stream%0d_pc4", i), id_pc_plus4, tbl[i].exp_pc4);
         end
      end

      // Decode stall: queue fills to DEPTH, requests stop, then drains in order.
      do_reset(1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         nxt();
         if (i >= 4) begin
            chk($sformatf("stall%0d_req", i), {31'b0, imem_req}, 32'h0);
            chk($sformatf("stall%0d_valid", i), {31'b0, id_valid}, 32'h1);
         end
      end
      for (int i = 0; i < 5; i++) begin
         nxt();
         id_ready = 1'b1;
         chk($sformatf("drain%0d_valid", i), {31'b0, id_valid}, 32'h1);
         chk($sformatf("drain%0d_instr", i), id_instr, heads[i]);
         chk($sformatf("drain%0d_pc4", i), id_pc_plus4, pc4s[i]);
      end

      // Redirect with 2 in flight plus one granted in the redirect cycle, latency 3.
      do_reset(3, 1'b0, 1'b1);
      nxt(); chk("r36_req", {31'b0, imem_req}, 32'h1); chk("r36_addr0", imem_addr, 32'h0);
      nxt(); imem_gnt = 1'b1; chk("r36_hold", imem_addr, 32'h0);
      nxt(); chk("r36_addr4", imem_addr, 32'h4);
      nxt(); redirect_valid = 1'b1; redirect_pc = 32'h100; chk("r36_addr8", imem_addr, 32'h8);
      nxt(); redirect_valid = 1'b0;
      chk("r36_newpc", imem_addr, 32'h100); chk("r36_flush", {31'b0, id_valid}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         nxt(); imem_gnt = 1'b0;
         chk($sformatf("r36_drop%0d", i), {31'b0, id_valid}, 32'h0);
      end
      nxt();
      chk("r36_valid", {31'b0, id_valid}, 32'h1);
      chk("r36_instr", id_instr, 32'hFFFF_FEFF);
      chk("r36_pc4", id_pc_plus4, 32'h104);

      // Redirect together with pop and rvalid on a nearly full queue; misaligned target.
      do_reset(1, 1'b1, 1'b0);
      repeat (4) nxt();
      nxt();
      chk("r37_pre_valid", {31'b0, id_valid}, 32'h1);
      chk("r37_pre_req", {31'b0, imem_req}, 32'h0);
      id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h203;
      nxt(); redirect_valid = 1'b0; id_ready = 1'b0;
      chk("r37_flush", {31'b0, id_valid}, 32'h0);
      chk("r37_newpc", imem_addr, 32'h200);
      chk("r37_req", {31'b0, imem_req}, 32'h1);
      nxt(); imem_gnt = 1'b0;
      chk("r37_addr_next", imem_addr, 32'h204);
      nxt();
      chk("r37_valid", {31'b0, id_valid}, 32'h1);
      chk("r37_instr", id_instr, 32'hFFFF_FDFF);
      chk("r37_pc4", id_pc_plus4, 32'h204);

      // PC wrap at the top of the address space.
      do_reset(1, 1'b0, 1'b0);
      nxt(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      nxt(); redirect_valid = 1'b0; imem_gnt = 1'b1;
      chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
      nxt(); imem_gnt = 1'b0;
      chk("wrap_zero", imem_addr, 32'h0);
      nxt();
      chk("wrap_instr", id_instr, 32'h3);
      chk("wrap_pc4", id_pc_plus4, 32'h0);

      // Asynchronous reset in the middle of a stream.
      do_reset(1, 1'b1, 1'b1);
      repeat (4) nxt();
      chk("mid_pre_valid", {31'b0, id_valid}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_req", {31'b0, imem_req}, 32'h0);
      chk("mid_valid", {31'b0, id_valid}, 32'h0);
      chk("mid_addr", imem_addr, 32'h0);
      do_reset(1, 1'b1, 1'b1);
      nxt(); chk("restart_req", {31'b0, imem_req}, 32'h1); chk("restart_addr0", imem_addr, 32'h0);
      nxt(); chk("restart_addr4", imem_addr, 32'h4);
      nxt();
      chk("restart_instr", id_instr, 32'hFFFF_FFFF);
      chk("restart_pc4", id_pc_plus4, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port imem_req  output  1  fetch request valid.
REQ-007 SHALL have port imem_addr  output  XLEN  fetch address, word aligned.
REQ-008 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-009 SHALL have port imem_rvalid  input  1  response valid; responses in request order, latency >=1.
REQ-010 SHALL have port imem_rdata  input  XLEN  response instruction.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump taken, one-cycle pulse.
REQ-012 SHALL have port redirect_pc  input  XLEN  new fetch address.
REQ-013 SHALL have port id_valid  output  1  head entry valid to decode.
REQ-014 SHALL have port id_instr  output  XLEN  head instruction.
REQ-015 SHALL have port id_pc_plus4  output  XLEN  head instruction address + 4.
REQ-016 SHALL have port id_ready  input  1  decode consumes head; low = hazard stall.

Function
REQ-017 SHALL assert imem_req only when queued + in-flight entries < DEPTH (credit rule); no response is ever dropped for lack of space.
REQ-018 SHALL advance fetch PC by 4 (modulo 2^XLEN, wrap silent) on each imem_req && imem_gnt.
REQ-019 SHALL hold imem_addr stable while imem_req high and imem_gnt low.
REQ-020 SHALL write imem_rdata with its pc+4 into the queue tail on imem_rvalid, unless being discarded (REQ-023).
REQ-021 SHALL pop head on id_valid && id_ready; id_* combinationally reflect head; id_valid = queue non-empty.
REQ-022 SHALL support simultaneous push and pop when full or empty; count unchanged, ordering preserved.
REQ-023 On redirect_valid: flush queue (id_valid low next cycle), set fetch PC to redirect_pc, load discard counter with in-flight count (including a request granted this cycle), and drop that many subsequent responses.
REQ-024 SHALL issue redirected fetch no earlier than the cycle after redirect_valid; may issue while discards pending if credits allow.
REQ-025 redirect_valid SHALL take priority over same-cycle pop, push and grant-driven PC increment.
REQ-026 Misaligned redirect_pc SHALL be forced to word alignment (bits [1:0] zeroed).
REQ-027 Pointers SHALL be log2(DEPTH) bits with wrap; count log2(DEPTH)+1 bits.

Reset
REQ-028 rst_n low SHALL asynchronously clear: fetch PC = RESET_PC, queue empty, in-flight = 0, discard = 0, imem_req = 0, id_valid = 0.
REQ-029 Responses arriving after reset for pre-reset requests are out of contract; memory is reset alongside.
REQ-030 First imem_req SHALL assert the first clock edge after rst_n deasserts.

Structure
REQ-031 XLEN default, word increment and PC alignment mask SHALL live in shared package pipeline_pkg.
REQ-032 Queue storage/pointers SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH, synchronous flush); fetch PC, credit and discard logic in fetch_queue.
REQ-033 No latches; all state on clk with async rst_n.

Verification
REQ-034 Reset, gnt=1, 1-cycle latency, id_ready=1 -> addresses 0,4,8,..., id_pc_plus4 = 4,8,12,... one instruction per cycle.
REQ-035 id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries queued, imem_req low, no data loss; release -> 4 pops in order.
REQ-036 3-cycle latency, redirect to 0x100 with 2 in-flight -> 2 responses discarded, next id_instr from 0x100, id_pc_plus4 = 0x104.
REQ-037 Redirect same cycle as pop and rvalid on full queue -> queue empty next cycle, PC = redirect_pc, in-flight counted into discard.
REQ-038 Fetch PC 0xFFFF_FFFC granted -> next imem_addr 0x0000_0000.
REQ-039 rst_n asserted mid-stream -> all outputs at reset values immediately; fetch restarts at RESET_PC.
